urv_dmem_responder: RTL and testbench
=====================================

URV_DMEM_RESPONDER -- requirements
Module: urv_dmem_responder

Interface
REQ-001 Parameter g_size_words, default 1024, memory depth in 32-bit words; SHALL be a power of two, 2 to 65536.
REQ-002 Parameter g_wait_states, default 0, extra cycles between request acceptance and completion; range 0 to 15.
REQ-003 Ports SHALL be:
- clk_i  in  1  single clock; all state on rising edge.
- rst_n_i  in  1  asynchronous, active-low reset.
- dm_addr_i  in  32  byte address of request.
- dm_data_s_i  in  32  store data.
- dm_data_select_i  in  4  byte-lane enables; bit n covers bits 8n+7:8n.
- dm_store_i  in  1  store request.
- dm_load_i  in  1  load request.
- dm_ready_o  out  1  responder can accept a request this cycle.
- dm_data_l_o  out  32  load data.
- dm_load_done_o  out  1  load-completion pulse.
- dm_store_done_o  out  1  store-completion pulse.
- err_o  out  1  sticky protocol-error flag.
REQ-004 Reset is asynchronous and active-low on rst_n_i; single clock clk_i.

Function
REQ-005 A request SHALL be accepted in cycle N iff (dm_load_i or dm_store_i) and dm_ready_o are high in N; other cycles SHALL be ignored.
REQ-006 Word index SHALL be dm_addr_i[log2(g_size_words)+1:2]; bits 1:0 and upper bits ignored, so addresses wrap modulo 4*g_size_words.
REQ-007 Store: lanes with dm_data_select_i bit set SHALL be written at the edge ending cycle N; other lanes unchanged; select 0000 still completes, writes nothing.
REQ-008 Load: SHALL return the full 32-bit word, ignoring dm_data_select_i; the word read SHALL reflect every store accepted before N.
REQ-009 Completion pulse (dm_load_done_o or dm_store_done_o) SHALL be high exactly one cycle, cycle N+1+g_wait_states.
REQ-010 dm_data_l_o SHALL be valid in the load_done cycle and hold until the next load_done; it SHALL NOT change on stores.
REQ-011 FSM states: IDLE (ready=1), WAIT (ready=0, counter decrements), DONE (pulse emitted).
- IDLE -> WAIT on acceptance if g_wait_states>0, counter loads g_wait_states-1.
- IDLE -> DONE on acceptance if g_wait_states=0.
- WAIT -> DONE when counter=0.
- DONE -> DONE on new acceptance with g_wait_states=0; DONE -> WAIT on new acceptance with g_wait_states>0; else DONE -> IDLE.
REQ-012 dm_ready_o SHALL be high in IDLE and DONE, low in WAIT; with g_wait_states=0 back-to-back requests every cycle SHALL be sustained.
REQ-013 Throughput with g_wait_states=W>0: one request per W+1 cycles max.
REQ-014 dm_load_i and dm_store_i both high at acceptance: store SHALL be performed, only dm_store_done_o pulsed, err_o set.
REQ-015 err_o SHALL stay set until reset.
REQ-016 Requests presented while dm_ready_o is low SHALL be ignored and SHALL NOT set err_o.
REQ-017 Load and store done SHALL never be high in the same cycle.

Reset
REQ-018 While rst_n_i low: dm_ready_o=0, dm_load_done_o=0, dm_store_done_o=0, dm_data_l_o=0, err_o=0, FSM=IDLE, counter=0.
REQ-019 dm_ready_o SHALL rise at the first rising clk_i after rst_n_i deasserts.
REQ-020 Reset mid-transaction SHALL abort it; no done pulse after release; memory contents SHALL NOT be cleared and are undefined in simulation until written.

Verification
REQ-021 W=0: store 0xDEADBEEF to 0x10, select 1111, cycle N -> store_done at N+1; load 0x10 at N+1 -> load_done at N+2 with data 0xDEADBEEF.
REQ-022 W=3: load accepted at N -> ready low N+1..N+3, load_done and ready high at N+4; request held during N+1..N+3 is ignored.
REQ-023 Byte lanes: store 0x11223344 full word, then 0xAABBCCDD with select 0101 -> load returns 0x11BB33DD.
REQ-024 Wrap: g_size_words=1024, store 0xCAFEF00D to 0x0; load 0x1000 and 0x1003 -> both return 0xCAFEF00D.
REQ-025 Load and store high together with data 0x5A5A5A5A -> store_done only, no load_done, err_o=1; next load of that address returns 0x5A5A5A5A.
REQ-026 W=2: assert rst_n_i low one cycle after acceptance -> outputs zero immediately, no done pulse after release, ready=1 at first clock after release.

Source files
------------

// File: rtl/urv_dmem_responder.sv
// Data-memory responder for a simple load/store master.
// Accepts one load or store per handshake (request & ready), performs the access on a
// word-addressed memory, and signals completion with a single-cycle done pulse after
// g_wait_states extra cycles.
//
// Ports:
//   clk_i            single clock, all state on the rising edge
//   rst_n_i          asynchronous active-low reset
//   dm_addr_i        byte address of the request (wraps modulo 4*g_size_words)
//   dm_data_s_i      store data
//   dm_data_select_i byte-lane enables for stores
//   dm_store_i       store request
//   dm_load_i        load request
//   dm_ready_o       a request can be accepted this cycle
//   dm_data_l_o      load data, held from one load_done to the next
//   dm_load_done_o   load-completion pulse
//   dm_store_done_o  store-completion pulse
//   err_o            sticky flag: load and store requested together
module urv_dmem_responder #(
  parameter int unsigned g_size_words  = 1024,
  parameter int unsigned g_wait_states = 0
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_data_s_i,
  input  logic [3:0]  dm_data_select_i,
  input  logic        dm_store_i,
  input  logic        dm_load_i,
  output logic        dm_ready_o,
  output logic [31:0] dm_data_l_o,
  output logic        dm_load_done_o,
  output logic        dm_store_done_o,
  output logic        err_o
);

  localparam int unsigned AddrW    = (g_size_words > 1) ? $clog2(g_size_words) : 1;
  localparam logic [3:0]  WaitLoad = (g_wait_states == 0) ? 4'd0 : 4'(g_wait_states - 1);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        op_load_q, op_load_d;
  logic        err_q, err_d;
  logic        rdy_en_q, rdy_en_d;
  logic [31:0] rd_q, rd_d;
  logic [31:0] data_l_q, data_l_d;
  logic [31:0] mem_q [g_size_words];

  logic [AddrW-1:0] idx;
  logic             accept;
  logic             is_store;
  logic             is_load;
  logic             unused_addr;

  assign idx         = dm_addr_i[AddrW+1:2];
  assign unused_addr = ^{dm_addr_i[31:AddrW+2], dm_addr_i[1:0]};

  // Ready is held low through reset and rises on the first clock after release.
  assign dm_ready_o = rdy_en_q & (state_q != StWait);
  assign accept     = dm_ready_o & (dm_load_i | dm_store_i);
  // A simultaneous load+store is treated as a store.
  assign is_store   = accept & dm_store_i;
  assign is_load    = accept & dm_load_i & ~dm_store_i;

  assign dm_load_done_o  = (state_q == StDone) & op_load_q;
  assign dm_store_done_o = (state_q == StDone) & ~op_load_q;
  // rd_q is captured at acceptance; expose it in the done cycle, then hold it.
  assign dm_data_l_o     = dm_load_done_o ? rd_q : data_l_q;
  assign err_o           = err_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_load_d = op_load_q;
    err_d     = err_q | (accept & dm_load_i & dm_store_i);
    rdy_en_d  = 1'b1;
    rd_d      = rd_q;
    data_l_d  = dm_load_done_o ? rd_q : data_l_q;

    if (is_load) begin
      rd_d = mem_q[idx];
    end

    if (accept) begin
      op_load_d = is_load;
      if (g_wait_states == 0) begin
        state_d = StDone;
      end else begin
        state_d = StWait;
        cnt_d   = WaitLoad;
      end
    end else begin
      unique case (state_q)
        StWait: begin
          if (cnt_q == 4'd0) begin
            state_d = StDone;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= StIdle;
      cnt_q     <= 4'd0;
      op_load_q <= 1'b0;
      err_q     <= 1'b0;
      rdy_en_q  <= 1'b0;
      rd_q      <= 32'd0;
      data_l_q  <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_load_q <= op_load_d;
      err_q     <= err_d;
      rdy_en_q  <= rdy_en_d;
      rd_q      <= rd_d;
      data_l_q  <= data_l_d;
    end
  end

  // Memory array is deliberately not reset; contents survive rst_n_i.
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < 4; b++) begin
      if (is_store && dm_data_select_i[b]) begin
        mem_q[idx][8*b +: 8] <= dm_data_s_i[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_urv_dmem_responder.sv
// Bench for urv_dmem_responder: three instances (wait states 0, 3, 2) checked against a
// word-level reference memory and the latency/pulse rules of the responder.
module tb_urv_dmem_responder;

  logic        clk;
  logic        rst_n;
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic [31:0] rdata [3];
  logic [3:0]  sel   [3];
  logic        st    [3];
  logic        ld    [3];
  logic        ready [3];
  logic        ldone [3];
  logic        sdone [3];
  logic        err   [3];

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] ref_mem [int];

  urv_dmem_responder #(.g_size_words(1024), .g_wait_states(0)) u_dut0 (
    .clk_i(clk), .rst_n_i(rst_n), .dm_addr_i(addr[0]), .dm_data_s_i(wdata[0]),
    .dm_data_select_i(sel[0]), .dm_store_i(st[0]), .dm_load_i(ld[0]), .dm_ready_o(ready[0]),
    .dm_data_l_o(rdata[0]), .dm_load_done_o(ldone[0]), .dm_store_done_o(sdone[0]),
    .err_o(err[0])
  );
  urv_dmem_responder #(.g_size_words(1024), .g_wait_states(3)) u_dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .dm_addr_i(addr[1]), .dm_data_s_i(wdata[1]),
    .dm_data_select_i(sel[1]), .dm_store_i(st[1]), .dm_load_i(ld[1]), .dm_ready_o(ready[1]),
    .dm_data_l_o(rdata[1]), .dm_load_done_o(ldone[1]), .dm_store_done_o(sdone[1]),
    .err_o(err[1])
  );
  urv_dmem_responder #(.g_size_words(1024), .g_wait_states(2)) u_dut2 (
    .clk_i(clk), .rst_n_i(rst_n), .dm_addr_i(addr[2]), .dm_data_s_i(wdata[2]),
    .dm_data_select_i(sel[2]), .dm_store_i(st[2]), .dm_load_i(ld[2]), .dm_ready_o(ready[2]),
    .dm_data_l_o(rdata[2]), .dm_load_done_o(ldone[2]), .dm_store_done_o(sdone[2]),
    .err_o(err[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int wst(input int i);
    case (i)
      0:       return 0;
      1:       return 3;
      default: return 2;
    endcase
  endfunction

  // Reference memory key: instance plus word index modulo 1024 words.
  function automatic int key(input int i, input logic [31:0] a);
    return i * 65536 + int'((a >> 2) & 32'h3FF);
  endfunction

  task automatic model_store(input int i, input logic [31:0] a, d, input logic [3:0] m);
    logic [31:0] w;
    w = ref_mem.exists(key(i, a)) ? ref_mem[key(i, a)] : 32'd0;
    for (int b = 0; b < 4; b++) if (m[b]) w[8*b +: 8] = d[8*b +: 8];
    ref_mem[key(i, a)] = w;
  endtask

  // Drives one request once ready, then measures cycles to the done pulse (-1 on timeout).
  task automatic issue(input int i, input bit l, input bit s, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] m, output int lat,
                       output bit gl, output bit gs, output logic [31:0] q);
    int n;
    lat = -1; gl = 1'b0; gs = 1'b0; q = '0;
    n = 0;
    while (ready[i] !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (ready[i] !== 1'b1) begin
      n_vec++; n_err++;
      $display("FAIL ready_timeout inst %0d: ready=%b required 1", i, ready[i]);
      return;
    end
    addr[i] = a; wdata[i] = d; sel[i] = m; ld[i] = l; st[i] = s;
    @(posedge clk); #1;
    ld[i] = 1'b0; st[i] = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (ldone[i] === 1'b1 || sdone[i] === 1'b1) begin
        lat = c; gl = ldone[i]; gs = sdone[i]; q = rdata[i];
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    #2;
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if ({ready[i], ldone[i], sdone[i], err[i], rdata[i]} !== 36'd0) begin
        n_err++;
        $display("FAIL reset_outputs inst %0d: got rdy=%b ld=%b sd=%b err=%b data=%h required 0",
                 i, ready[i], ldone[i], sdone[i], err[i], rdata[i]);
      end
    end
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1; #1;
    n_vec++;
    if (ready[0] !== 1'b0) begin
      n_err++; $display("FAIL ready_before_clock: got %b required 0", ready[0]);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (ready[i] !== 1'b1) begin
        n_err++; $display("FAIL ready_after_release inst %0d: got %b required 1", i, ready[i]);
      end
    end
  endtask

  task automatic test_basic();
    int lat; bit gl, gs; logic [31:0] q;
    issue(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, lat, gl, gs, q);
    model_store(0, 32'h10, 32'hDEADBEEF, 4'hF);
    n_vec++;
    if (lat != 1 || gs !== 1'b1 || gl !== 1'b0) begin
      n_err++; $display("FAIL basic_store: got lat=%0d ld=%b sd=%b required lat=1 ld=0 sd=1",
                        lat, gl, gs);
    end
    issue(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, lat, gl, gs, q);
    n_vec++;
    if (lat != 1 || gl !== 1'b1 || gs !== 1'b0 || q !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL basic_load: got lat=%0d ld=%b sd=%b data=%h required 1 1 0 deadbeef",
                        lat, gl, gs, q);
    end
  endtask

  task automatic test_lanes();
    int lat; bit gl, gs; logic [31:0] q;
    for (int i = 0; i < 2; i++) begin
      issue(i, 1'b0, 1'b1, 32'h30, 32'h11223344, 4'hF, lat, gl, gs, q);
      issue(i, 1'b0, 1'b1, 32'h30, 32'hAABBCCDD, 4'b0101, lat, gl, gs, q);
      issue(i, 1'b0, 1'b1, 32'h30, 32'hFFFFFFFF, 4'b0000, lat, gl, gs, q);
      n_vec++;
      if (lat != 1 + wst(i) || gs !== 1'b1) begin
        n_err++; $display("FAIL lanes_zero_select inst %0d: got lat=%0d sd=%b required lat=%0d sd=1",
                          i, lat, gs, 1 + wst(i));
      end
      model_store(i, 32'h30, 32'h11223344, 4'hF);
      model_store(i, 32'h30, 32'hAABBCCDD, 4'b0101);
      issue(i, 1'b1, 1'b0, 32'h30, 32'h0, 4'hF, lat, gl, gs, q);
      n_vec++;
      if (q !== 32'h11BB33DD || gl !== 1'b1) begin
        n_err++; $display("FAIL lanes_merge inst %0d: got %h ld=%b required 11bb33dd", i, q, gl);
      end
    end
  endtask

  task automatic test_wrap();
    int lat; bit gl, gs; logic [31:0] q;
    issue(0, 1'b0, 1'b1, 32'h0, 32'hCAFEF00D, 4'hF, lat, gl, gs, q);
    model_store(0, 32'h0, 32'hCAFEF00D, 4'hF);
    issue(0, 1'b1, 1'b0, 32'h1000, 32'h0, 4'h0, lat, gl, gs, q);
    n_vec++;
    if (q !== 32'hCAFEF00D) begin
      n_err++; $display("FAIL wrap_1000: got %h required cafef00d", q);
    end
    issue(0, 1'b1, 1'b0, 32'h1003, 32'h0, 4'h0, lat, gl, gs, q);
    n_vec++;
    if (q !== 32'hCAFEF00D) begin
      n_err++; $display("FAIL wrap_1003: got %h required cafef00d", q);
    end
  endtask

  task automatic test_wait_states();
    int lat; bit gl, gs; logic [31:0] q;
    issue(1, 1'b0, 1'b1, 32'h40, 32'h0BADF00D, 4'hF, lat, gl, gs, q);
    issue(1, 1'b0, 1'b1, 32'h44, 32'h12345678, 4'hF, lat, gl, gs, q);
    model_store(1, 32'h40, 32'h0BADF00D, 4'hF);
    model_store(1, 32'h44, 32'h12345678, 4'hF);
    addr[1] = 32'h40; ld[1] = 1'b1;
    @(posedge clk); #1;
    addr[1] = 32'h44; st[1] = 1'b1;  // held load+store while busy must be ignored
    for (int k = 1; k <= 3; k++) begin
      n_vec++;
      if (ready[1] !== 1'b0 || ldone[1] !== 1'b0 || sdone[1] !== 1'b0) begin
        n_err++; $display("FAIL wait_busy N+%0d: got rdy=%b ld=%b sd=%b required 0 0 0",
                          k, ready[1], ldone[1], sdone[1]);
      end
      @(posedge clk); #1;
    end
    n_vec++;
    if (ready[1] !== 1'b1 || ldone[1] !== 1'b1 || rdata[1] !== 32'h0BADF00D) begin
      n_err++; $display("FAIL wait_done: got rdy=%b ld=%b data=%h required 1 1 0badf00d",
                        ready[1], ldone[1], rdata[1]);
    end
    ld[1] = 1'b0; st[1] = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      n_vec++;
      if (ldone[1] !== 1'b0 || sdone[1] !== 1'b0 || rdata[1] !== 32'h0BADF00D) begin
        n_err++; $display("FAIL wait_ignored cycle %0d: got ld=%b sd=%b data=%h required 0 0 0badf00d",
                          k, ldone[1], sdone[1], rdata[1]);
      end
    end
    n_vec++;
    if (err[1] !== 1'b0) begin
      n_err++; $display("FAIL wait_no_err: got %b required 0", err[1]);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, d, exp_q;
    for (int k = 0; k < 6; k++) begin
      a = 32'h80 + 32'(4 * k); d = $urandom;
      addr[0] = a; wdata[0] = d; sel[0] = 4'hF; st[0] = 1'b1;
      model_store(0, a, d, 4'hF);
      @(posedge clk); #1;
      n_vec++;
      if (sdone[0] !== 1'b1 || ready[0] !== 1'b1) begin
        n_err++; $display("FAIL b2b_store %0d: got sd=%b rdy=%b required 1 1", k, sdone[0], ready[0]);
      end
    end
    st[0] = 1'b0;
    for (int k = 0; k < 6; k++) begin
      a = 32'h80 + 32'(4 * k);
      addr[0] = a; ld[0] = 1'b1;
      exp_q = ref_mem[key(0, a)];
      @(posedge clk); #1;
      n_vec++;
      if (ldone[0] !== 1'b1 || rdata[0] !== exp_q) begin
        n_err++; $display("FAIL b2b_load %0d: got ld=%b data=%h required 1 %h", k, ldone[0],
                          rdata[0], exp_q);
      end
    end
    ld[0] = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if (ldone[0] !== 1'b0) begin
      n_err++; $display("FAIL b2b_single_pulse: got %b required 0", ldone[0]);
    end
  endtask

  task automatic test_conflict();
    int lat; bit gl, gs; logic [31:0] q;
    n_vec++;
    if (err[2] !== 1'b0) begin
      n_err++; $display("FAIL conflict_pre_err: got %b required 0", err[2]);
    end
    issue(2, 1'b1, 1'b1, 32'h20, 32'h5A5A5A5A, 4'hF, lat, gl, gs, q);
    model_store(2, 32'h20, 32'h5A5A5A5A, 4'hF);
    n_vec++;
    if (lat != 3 || gs !== 1'b1 || gl !== 1'b0 || err[2] !== 1'b1) begin
      n_err++; $display("FAIL conflict_store: got lat=%0d ld=%b sd=%b err=%b required 3 0 1 1",
                        lat, gl, gs, err[2]);
    end
    issue(2, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0, lat, gl, gs, q);
    n_vec++;
    if (q !== 32'h5A5A5A5A || err[2] !== 1'b1) begin
      n_err++; $display("FAIL conflict_load: got data=%h err=%b required 5a5a5a5a 1", q, err[2]);
    end
  endtask

  task automatic test_random();
    int lat; bit gl, gs, is_ld; logic [31:0] q, a, d, prev, exp_q; logic [3:0] m;
    for (int i = 0; i < 3; i++) begin
      for (int w = 0; w < 16; w++) begin
        d = $urandom;
        issue(i, 1'b0, 1'b1, 32'(w << 2), d, 4'hF, lat, gl, gs, q);
        model_store(i, 32'(w << 2), d, 4'hF);
      end
      for (int n = 0; n < 40; n++) begin
        a = 32'($urandom_range(0, 7) << 12) | 32'($urandom_range(0, 15) << 2) |
            32'($urandom_range(0, 3));
        d = $urandom; m = 4'($urandom_range(0, 15)); is_ld = 1'($urandom_range(0, 1));
        prev = rdata[i];
        issue(i, is_ld, !is_ld, a, d, m, lat, gl, gs, q);
        n_vec++;
        if (lat != 1 + wst(i) || gl !== is_ld || gs !== !is_ld) begin
          n_err++; $display("FAIL rand_timing inst %0d op %0d: got lat=%0d ld=%b sd=%b required %0d %b %b",
                            i, n, lat, gl, gs, 1 + wst(i), is_ld, !is_ld);
        end
        if (is_ld) begin
          exp_q = ref_mem[key(i, a)];
        end else begin
          model_store(i, a, d, m);
          exp_q = prev;
        end
        n_vec++;
        if (q !== exp_q) begin
          n_err++; $display("FAIL rand_data inst %0d op %0d ld=%b addr=%h: got %h required %h",
                            i, n, is_ld, a, q, exp_q);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int lat; bit gl, gs; logic [31:0] q;
    addr[2] = 32'h24; wdata[2] = 32'h600DCAFE; sel[2] = 4'hF; st[2] = 1'b1;
    @(posedge clk); #1;
    st[2] = 1'b0;
    model_store(2, 32'h24, 32'h600DCAFE, 4'hF);
    rst_n = 1'b0; #1;
    n_vec++;
    if ({ready[2], ldone[2], sdone[2], err[2], rdata[2]} !== 36'd0) begin
      n_err++; $display("FAIL midreset_outputs: got rdy=%b ld=%b sd=%b err=%b data=%h required 0",
                        ready[2], ldone[2], sdone[2], err[2], rdata[2]);
    end
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if (ready[2] !== 1'b1) begin
      n_err++; $display("FAIL midreset_ready: got %b required 1", ready[2]);
    end
    for (int k = 0; k < 6; k++) begin
      n_vec++;
      if (ldone[2] !== 1'b0 || sdone[2] !== 1'b0) begin
        n_err++; $display("FAIL midreset_no_done cycle %0d: got ld=%b sd=%b required 0 0",
                          k, ldone[2], sdone[2]);
      end
      @(posedge clk); #1;
    end
    issue(2, 1'b1, 1'b0, 32'h24, 32'h0, 4'h0, lat, gl, gs, q);
    n_vec++;
    if (q !== 32'h600DCAFE || lat != 3) begin
      n_err++; $display("FAIL midreset_mem_kept: got data=%h lat=%0d required 600dcafe 3", q, lat);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      addr[i] = '0; wdata[i] = '0; sel[i] = '0; st[i] = 1'b0; ld[i] = 1'b0;
    end
    test_reset();
    test_basic();
    test_lanes();
    test_wrap();
    test_wait_states();
    test_back_to_back();
    test_conflict();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
